out_ser: RTL



---
 rtl/out_ser.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/out_ser.sv
// out_ser: parallel-to-serial output stage for the output-pad path.
// Accepts a WIDTH-bit word over valid/ready and shifts it out one bit per clock.
// Optional feature macro: OUT_SER_PARITY_EN appends an even-parity bit to each frame.
module out_ser #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter logic        OUT_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataInValid,
  output logic             dataInReady,
  output logic             serOut,
  output logic             serSel,
  output logic             serValid,
  output logic             busy
);

  localparam int unsigned    CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

`ifdef OUT_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_d;
  logic             ser_valid_d;
  logic             live_q;
  logic             first_bit;
  logic             next_bit;
  logic             last_bit;
  logic             accept;
`ifdef OUT_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, ready and next-output decode; an accept always (re)loads a frame
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = IDLE_LEVEL;
    ser_valid_d = 1'b0;
    dataInReady = 1'b0;
`ifdef OUT_SER_PARITY_EN
    par_d       = par_q;
`endif
    first_bit   = MSB_FIRST ? dataIn[WIDTH-1] : dataIn[0];
    next_bit    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    last_bit    = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        dataInReady = live_q;
      end
      SHIFT: begin
`ifndef OUT_SER_PARITY_EN
        dataInReady = live_q && last_bit;
`endif
        if (!last_bit) begin
          sreg_d      = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          cnt_d       = cnt_q - CNT_W'(1);
          ser_out_d   = next_bit;
          ser_valid_d = 1'b1;
`ifdef OUT_SER_PARITY_EN
          par_d       = par_q ^ next_bit;
`endif
        end else begin
`ifdef OUT_SER_PARITY_EN
          state_d     = PARITY;
          ser_out_d   = par_q;
          ser_valid_d = 1'b1;
`else
          state_d     = IDLE;
`endif
        end
      end
`ifdef OUT_SER_PARITY_EN
      PARITY: begin
        dataInReady = live_q;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    accept = dataInValid && dataInReady;
    if (accept) begin
      state_d     = SHIFT;
      sreg_d      = MSB_FIRST ? (dataIn << 1) : (dataIn >> 1);
      cnt_d       = CNT_LOAD;
      ser_out_d   = first_bit;
      ser_valid_d = 1'b1;
`ifdef OUT_SER_PARITY_EN
      par_d       = first_bit;
`endif
    end
  end

  // Datapath and output registers; live_q holds ready low until reset has been released
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      serOut   <= IDLE_LEVEL;
      serValid <= 1'b0;
      busy     <= 1'b0;
      serSel   <= 1'b0;
      live_q   <= 1'b0;
`ifdef OUT_SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      serOut   <= ser_out_d;
      serValid <= ser_valid_d;
      busy     <= (state_d != IDLE);
      serSel   <= OUT_BYPASS;
      live_q   <= 1'b1;
`ifdef OUT_SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
